ysyx_25040111_axi_sram: RTL and testbench



---
 rtl/ysyx_25040111_axi_sram.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_axi_sram.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_axi_sram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ysyx_25040111_axi_sram
// Description : AXI4 responder word RAM with configurable read/write latency.
//               Serves one transaction at a time, supports INCR/FIXED bursts,
//               echoes IDs and reports OKAY/SLVERR/DECERR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040111_axi_sram #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    // write address channel
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    // write data channel
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    // write response channel
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    // read address channel
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    // read data channel
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int          c_IDX_W  = $clog2(MEM_WORDS);
    localparam logic [31:0] c_SPAN   = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  c_RD_LAT = 4'(RD_LAT);
    localparam logic [3:0]  c_WR_LAT = 4'(WR_LAT);

    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;
    localparam logic [1:0]  c_DECERR = 2'b11;

    localparam logic [2:0]  c_S_IDLE  = 3'd0;
    localparam logic [2:0]  c_S_RWAIT = 3'd1;
    localparam logic [2:0]  c_S_RDATA = 3'd2;
    localparam logic [2:0]  c_S_WDATA = 3'd3;
    localparam logic [2:0]  c_S_WWAIT = 3'd4;
    localparam logic [2:0]  c_S_WRESP = 3'd5;

    // Responses are ordered so that the numerically larger code is the worse one.
    function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [31:0]        r_mem [MEM_WORDS];

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic [7:0]         r_len;
    logic               r_fixed;
    logic               r_cfg_err;
    logic [8:0]         r_beat;
    logic [1:0]         r_wresp;

    logic               w_ar_hs;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_r_hs;
    logic               w_ar_cfg_err;
    logic               w_aw_cfg_err;

    logic [31:0]        w_next_addr;
    logic [31:0]        w_off;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;

    logic               w_fetch;
    logic [31:0]        w_f_addr;
    logic [31:0]        w_f_off;
    logic               w_f_in;
    logic [c_IDX_W-1:0] w_f_idx;
    logic [7:0]         w_f_beat;
    logic [1:0]         w_f_resp;
    logic [31:0]        w_f_data;

    logic               w_beat_in_len;
    logic [1:0]         w_beat_resp;
    logic [1:0]         w_last_resp;
    logic [1:0]         w_wresp_nxt;
    logic               w_wr_en;

    assign w_ar_hs = arvalid && arready;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_r_hs  = rvalid && rready;

    // Only 32-bit beats and FIXED/INCR bursts are supported (WRAP and reserved have bit 1 set).
    assign w_ar_cfg_err = (arsize != 3'b010) || arburst[1];
    assign w_aw_cfg_err = (awsize != 3'b010) || awburst[1];

    assign w_next_addr = r_fixed ? r_addr : r_addr + 32'd4;

    // Current-beat decode, used by the write path. Addresses below BASE wrap to
    // huge offsets, so a single unsigned compare covers both ends of the window.
    assign w_off      = r_addr - BASE;
    assign w_in_range = (w_off < c_SPAN);
    assign w_idx      = w_off[c_IDX_W+1:2];

    // Read fetch decode: the first beat uses the latched address, later beats the advanced one.
    assign w_fetch  = ((r_state == c_S_RWAIT) && (r_cnt == 4'd0)) || (w_r_hs && !rlast);
    assign w_f_addr = (r_state == c_S_RDATA) ? w_next_addr : r_addr;
    assign w_f_off  = w_f_addr - BASE;
    assign w_f_in   = (w_f_off < c_SPAN);
    assign w_f_idx  = w_f_off[c_IDX_W+1:2];
    assign w_f_beat = (r_state == c_S_RDATA) ? (r_beat[7:0] + 8'd1) : 8'd0;
    assign w_f_resp = f_worst(w_f_in ? c_OKAY : c_DECERR, r_cfg_err ? c_SLVERR : c_OKAY);
    assign w_f_data = (w_f_in && !r_cfg_err) ? r_mem[w_f_idx] : 32'd0;

    // Write beat qualification: beats beyond awlen+1 are swallowed without touching RAM.
    assign w_beat_in_len = (r_beat <= {1'b0, r_len});
    assign w_beat_resp   = (w_beat_in_len && !w_in_range) ? c_DECERR : c_OKAY;
    assign w_last_resp   = (wlast && (r_beat != {1'b0, r_len})) ? c_SLVERR : c_OKAY;
    assign w_wresp_nxt   = f_worst(r_wresp, f_worst(w_beat_resp, w_last_resp));
    assign w_wr_en       = w_w_hs && w_beat_in_len && w_in_range && !r_cfg_err;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and channel ready/valid outputs; everything is held low during reset.
    always_comb begin
        w_next_state = r_state;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        rvalid       = 1'b0;
        bvalid       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
                if (arvalid) begin
                    w_next_state = c_S_RWAIT;
                end else if (awvalid) begin
                    w_next_state = c_S_WDATA;
                end
            end
            c_S_RWAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_S_RDATA;
                end
            end
            c_S_RDATA: begin
                rvalid = 1'b1;
                if (rready && rlast) begin
                    w_next_state = c_S_IDLE;
                end
            end
            c_S_WDATA: begin
                wready = 1'b1;
                if (wvalid && wlast) begin
                    w_next_state = c_S_WWAIT;
                end
            end
            c_S_WWAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_S_WRESP;
                end
            end
            c_S_WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
        if (reset) begin
            arready = 1'b0;
            awready = 1'b0;
            wready  = 1'b0;
            rvalid  = 1'b0;
            bvalid  = 1'b0;
        end
    end

    // Transaction context, latency counter and registered response/data outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_fixed   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_beat    <= 9'd0;
            r_wresp   <= c_OKAY;
            rid       <= 4'd0;
            bid       <= 4'd0;
            rdata     <= 32'd0;
            rresp     <= c_OKAY;
            rlast     <= 1'b0;
            bresp     <= c_OKAY;
        end else begin
            if (w_ar_hs) begin
                rid       <= arid;
                r_addr    <= araddr;
                r_len     <= arlen;
                r_fixed   <= (arburst == 2'b00);
                r_cfg_err <= w_ar_cfg_err;
                r_cnt     <= c_RD_LAT;
                r_beat    <= 9'd0;
            end else if (w_aw_hs) begin
                bid       <= awid;
                r_addr    <= awaddr;
                r_len     <= awlen;
                r_fixed   <= (awburst == 2'b00);
                r_cfg_err <= w_aw_cfg_err;
                r_beat    <= 9'd0;
                r_wresp   <= w_aw_cfg_err ? c_SLVERR : c_OKAY;
            end

            if (((r_state == c_S_RWAIT) || (r_state == c_S_WWAIT)) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_fetch) begin
                rdata <= w_f_data;
                rresp <= w_f_resp;
                rlast <= (w_f_beat == r_len);
                if (r_state == c_S_RDATA) begin
                    r_addr <= w_next_addr;
                    r_beat <= r_beat + 9'd1;
                end
            end

            if (w_w_hs) begin
                r_addr  <= w_next_addr;
                r_wresp <= w_wresp_nxt;
                if (r_beat != 9'h1FF) begin
                    r_beat <= r_beat + 9'd1;
                end
                if (wlast) begin
                    r_cnt <= c_WR_LAT;
                end
            end

            if ((r_state == c_S_WWAIT) && (r_cnt == 4'd0)) begin
                bresp <= r_wresp;
            end
        end
    end

    // Byte-enabled RAM write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_axi_sram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ysyx_25040111_axi_sram
// Description : Directed self-checking bench for the AXI4 SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_axi_sram;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          MEM_WORDS = 1024;
    localparam int          RD_LAT    = 2;
    localparam int          WR_LAT    = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awready, awvalid = 1'b0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        wready, wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        bready = 1'b0, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rready = 1'b0, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id;

    ysyx_25040111_axi_sram #(
        .MEM_WORDS (MEM_WORDS),
        .BASE      (BASE),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clock   (clock),   .reset   (reset),
        .awready (awready), .awvalid (awvalid), .awaddr (awaddr), .awid (awid),
        .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst),
        .wready  (wready),  .wvalid  (wvalid),  .wdata  (wdata),  .wstrb (wstrb), .wlast (wlast),
        .bready  (bready),  .bvalid  (bvalid),  .bresp  (bresp),  .bid   (bid),
        .arready (arready), .arvalid (arvalid), .araddr (araddr), .arid  (arid),
        .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst),
        .rready  (rready),  .rvalid  (rvalid),  .rresp  (rresp),  .rdata (rdata),
        .rlast   (rlast),   .rid     (rid)
    );

    always #5 clock = ~clock;

    // ---------------- stimulus helpers (handshake only) ----------------
    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n;
        @(negedge clock);
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu;
        #1; n = 0;
        while (!awready && n < 100) begin @(negedge clock); #1; n++; end
        if (!awready) begin
            checks++; failures++;
            $display("FAIL aw_timeout awready=%0b required=1", awready);
        end
        @(posedge clock); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        @(negedge clock);
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
        #1; n = 0;
        while (!wready && n < 100) begin @(negedge clock); #1; n++; end
        if (!wready) begin
            checks++; failures++;
            $display("FAIL w_timeout wready=%0b required=1", wready);
        end
        @(posedge clock); #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id, output int lat);
        lat = 0;
        @(negedge clock); #1;
        while (!bvalid && lat < 50) begin @(posedge clock); lat++; @(negedge clock); #1; end
        if (!bvalid) begin
            checks++; failures++;
            $display("FAIL b_timeout bvalid=%0b required=1", bvalid);
        end
        resp = bresp; id = bid;
        bready = 1'b1;
        @(posedge clock); #1 bready = 1'b0;
    endtask

    task automatic write1(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp, output logic [3:0] rbid,
                          output int lat);
        send_aw(a, id, 8'd0, 3'b010, 2'b01);
        send_w(d, s, 1'b1);
        wait_b(resp, rbid, lat);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n;
        @(negedge clock);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu;
        #1; n = 0;
        while (!arready && n < 100) begin @(negedge clock); #1; n++; end
        if (!arready) begin
            checks++; failures++;
            $display("FAIL ar_timeout arready=%0b required=1", arready);
        end
        @(posedge clock); #1 arvalid = 1'b0;
    endtask

    // Collects beats into got_*; with toggle set, rready alternates 0,1,0,1...
    task automatic recv(input bit toggle, output int nb, output int lat, output bit stable);
        bit          phase, stalled, acc, done;
        logic [31:0] held;
        int          guard;
        lat = 0; nb = 0; stable = 1'b1; phase = 1'b0; stalled = 1'b0; done = 1'b0; guard = 0;
        held = '0;
        @(negedge clock); #1;
        while (!rvalid && lat < 50) begin @(posedge clock); lat++; @(negedge clock); #1; end
        if (!rvalid) begin
            checks++; failures++;
            $display("FAIL r_timeout rvalid=%0b required=1", rvalid);
            done = 1'b1;
        end
        while (!done && guard < 64) begin
            guard++;
            if (stalled && (rdata !== held || !rvalid)) stable = 1'b0;
            rready = toggle ? phase : 1'b1;
            phase  = ~phase;
            acc    = rvalid && rready && (nb < 16);
            if (acc) begin
                got_data[nb] = rdata; got_resp[nb] = rresp; got_last[nb] = rlast; got_id = rid;
            end
            held = rdata; stalled = !rready;
            @(posedge clock);
            if (acc) begin
                nb++;
                if (got_last[nb-1]) done = 1'b1;
            end
            if (!done) begin @(negedge clock); #1; end
        end
        #1 rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({arready, awready, wready} !== 3'b000) begin
            failures++; $display("FAIL reset_ready got=%b required=000", {arready, awready, wready});
        end
        checks++;
        if ({rvalid, bvalid} !== 2'b00) begin
            failures++; $display("FAIL reset_valid got=%b required=00", {rvalid, bvalid});
        end
        checks++;
        if ({bresp, rresp, rdata, rlast, rid, bid} !== '0) begin
            failures++; $display("FAIL reset_outputs rdata=%h rresp=%b bresp=%b rlast=%b rid=%h bid=%h required=0",
                                 rdata, rresp, bresp, rlast, rid, bid);
        end
        @(negedge clock); reset = 1'b0; #1;
        checks++;
        if ({arready, awready} !== 2'b11) begin
            failures++; $display("FAIL idle_ready got=%b required=11", {arready, awready});
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; logic [3:0] rb; int lat, nb; bit st;
        write1(BASE + 32'h10, 4'd3, 32'hDEADBEEF, 4'hF, resp, rb, lat);
        checks++;
        if (resp !== 2'b00 || rb !== 4'd3) begin
            failures++; $display("FAIL single_b bresp=%b bid=%0d required 00/3", resp, rb);
        end
        checks++;
        if (lat != WR_LAT + 1) begin
            failures++; $display("FAIL single_b_latency got=%0d required=%0d", lat, WR_LAT + 1);
        end
        send_ar(BASE + 32'h10, 4'd5, 8'd0, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (lat != RD_LAT + 1) begin
            failures++; $display("FAIL single_r_latency got=%0d required=%0d", lat, RD_LAT + 1);
        end
        checks++;
        if (nb != 1 || got_data[0] !== 32'hDEADBEEF || got_last[0] !== 1'b1) begin
            failures++; $display("FAIL single_r_data beats=%0d data=%h last=%b required 1/deadbeef/1",
                                 nb, got_data[0], got_last[0]);
        end
        checks++;
        if (got_id !== 4'd5 || got_resp[0] !== 2'b00) begin
            failures++; $display("FAIL single_r_id rid=%0d rresp=%b required 5/00", got_id, got_resp[0]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [3:0] rb; int lat, nb; bit st;
        write1(BASE + 32'h20, 4'd1, 32'h11223344, 4'hF, resp, rb, lat);
        write1(BASE + 32'h20, 4'd1, 32'h0000AA00, 4'b0010, resp, rb, lat);
        send_ar(BASE + 32'h20, 4'd1, 8'd0, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_data[0] !== 32'h1122AA44) begin
            failures++; $display("FAIL strobe_merge got=%h required=1122aa44", got_data[0]);
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp; logic [3:0] rb; int lat, nb; bit st;
        send_aw(BASE + 32'h100, 4'd2, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'(i + 1), 4'hF, i == 3);
        wait_b(resp, rb, lat);
        checks++;
        if (resp !== 2'b00) begin
            failures++; $display("FAIL incr_bresp got=%b required=00", resp);
        end
        send_ar(BASE + 32'h100, 4'd7, 8'd3, 3'b010, 2'b01);
        recv(1'b1, nb, lat, st);
        checks++;
        if (nb != 4) begin
            failures++; $display("FAIL incr_beats got=%0d required=4", nb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== 32'(i + 1) || got_last[i] !== (i == 3)) begin
                failures++; $display("FAIL incr_beat%0d data=%h last=%b required %h/%b",
                                     i, got_data[i], got_last[i], 32'(i + 1), (i == 3));
            end
        end
        checks++;
        if (!st) begin
            failures++; $display("FAIL incr_stall_stable got=0 required=1");
        end
        send_ar(BASE + 32'h104, 4'd8, 8'd1, 3'b010, 2'b00);
        recv(1'b0, nb, lat, st);
        checks++;
        if (nb != 2 || got_data[0] !== 32'd2 || got_data[1] !== 32'd2) begin
            failures++; $display("FAIL fixed_read beats=%0d d0=%h d1=%h required 2/2/2",
                                 nb, got_data[0], got_data[1]);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic [3:0] rb; int lat, n; bit bad;
        @(negedge clock);
        arvalid = 1'b1; araddr = BASE + 32'h20; arid = 4'd2; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01;
        awvalid = 1'b1; awaddr = BASE + 32'h40; awid = 4'd9; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01;
        #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin
            failures++; $display("FAIL collide_ready got=%b required=10", {arready, awready});
        end
        @(posedge clock); #1 arvalid = 1'b0;
        bad = 1'b0; n = 0;
        @(negedge clock); #1;
        while (!rvalid && n < 20) begin
            if (awready) bad = 1'b1;
            @(negedge clock); #1; n++;
        end
        if (awready) bad = 1'b1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h1122AA44) begin
            failures++; $display("FAIL collide_read rvalid=%b data=%h required 1/1122aa44", rvalid, rdata);
        end
        rready = 1'b1;
        @(posedge clock); #1 rready = 1'b0;
        checks++;
        if (bad) begin
            failures++; $display("FAIL collide_aw_blocked awready_seen=1 required=0");
        end
        @(negedge clock); #1;
        checks++;
        if (awready !== 1'b1) begin
            failures++; $display("FAIL collide_aw_after got=%b required=1", awready);
        end
        @(posedge clock); #1 awvalid = 1'b0;
        send_w(32'h55AA55AA, 4'hF, 1'b1);
        wait_b(resp, rb, lat);
        checks++;
        if (resp !== 2'b00 || rb !== 4'd9) begin
            failures++; $display("FAIL collide_b bresp=%b bid=%0d required 00/9", resp, rb);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [3:0] rb; int lat, nb; bit st;
        write1(BASE, 4'd1, 32'hCAFEF00D, 4'hF, resp, rb, lat);
        send_ar(BASE + 32'(4 * MEM_WORDS), 4'd1, 8'd0, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_resp[0] !== 2'b11 || got_data[0] !== 32'd0) begin
            failures++; $display("FAIL oor_read rresp=%b data=%h required 11/0", got_resp[0], got_data[0]);
        end
        write1(BASE + 32'(4 * MEM_WORDS), 4'd1, 32'h12345678, 4'hF, resp, rb, lat);
        checks++;
        if (resp !== 2'b11) begin
            failures++; $display("FAIL oor_write bresp=%b required=11", resp);
        end
        send_ar(BASE, 4'd1, 8'd0, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_data[0] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL oor_word0 got=%h required=cafef00d", got_data[0]);
        end
        send_ar(BASE - 32'd4, 4'd1, 8'd0, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_resp[0] !== 2'b11) begin
            failures++; $display("FAIL below_base rresp=%b required=11", got_resp[0]);
        end
        send_aw(BASE + 32'h60, 4'd4, 8'd2, 3'b010, 2'b01);
        send_w(32'hA, 4'hF, 1'b0);
        send_w(32'hB, 4'hF, 1'b1);
        wait_b(resp, rb, lat);
        checks++;
        if (resp !== 2'b10) begin
            failures++; $display("FAIL short_wlast bresp=%b required=10", resp);
        end
        write1(BASE + 32'h74, 4'd1, 32'h0, 4'hF, resp, rb, lat);
        send_aw(BASE + 32'h70, 4'd4, 8'd0, 3'b010, 2'b01);
        send_w(32'h70707070, 4'hF, 1'b0);
        send_w(32'h74747474, 4'hF, 1'b1);
        wait_b(resp, rb, lat);
        checks++;
        if (resp !== 2'b10) begin
            failures++; $display("FAIL long_wlast bresp=%b required=10", resp);
        end
        send_ar(BASE + 32'h70, 4'd1, 8'd1, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_data[0] !== 32'h70707070 || got_data[1] !== 32'h0) begin
            failures++; $display("FAIL extra_beat_dropped d0=%h d1=%h required 70707070/0",
                                 got_data[0], got_data[1]);
        end
        send_ar(BASE + 32'h10, 4'd1, 8'd0, 3'b010, 2'b10);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_resp[0] !== 2'b10) begin
            failures++; $display("FAIL wrap_burst rresp=%b required=10", got_resp[0]);
        end
        send_ar(BASE + 32'h10, 4'd1, 8'd0, 3'b001, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (got_resp[0] !== 2'b10) begin
            failures++; $display("FAIL bad_size rresp=%b required=10", got_resp[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [3:0] rb; int lat, nb, n; bit st;
        send_aw(BASE + 32'h200, 4'd6, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hA000_0000 + 32'(i), 4'hF, i == 3);
        wait_b(resp, rb, lat);
        send_ar(BASE + 32'h200, 4'd6, 8'd3, 3'b010, 2'b01);
        n = 0;
        @(negedge clock); #1;
        while (!rvalid && n < 20) begin @(negedge clock); #1; n++; end
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hA000_0001) begin
            failures++; $display("FAIL midreset_beat2 rvalid=%b data=%h required 1/a0000001", rvalid, rdata);
        end
        reset = 1'b1; #1;
        checks++;
        if ({rvalid, arready} !== 2'b00) begin
            failures++; $display("FAIL midreset_drop got=%b required=00", {rvalid, arready});
        end
        rready = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0; #1;
        checks++;
        if ({arready, rvalid} !== 2'b10) begin
            failures++; $display("FAIL midreset_idle got=%b required=10", {arready, rvalid});
        end
        send_ar(BASE + 32'h200, 4'd6, 8'd3, 3'b010, 2'b01);
        recv(1'b0, nb, lat, st);
        checks++;
        if (nb != 4 || got_data[0] !== 32'hA000_0000 || got_data[3] !== 32'hA000_0003) begin
            failures++; $display("FAIL midreset_data beats=%0d d0=%h d3=%h required 4/a0000000/a0000003",
                                 nb, got_data[0], got_data[3]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_incr();
        test_collision();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
